// File: rtl/tick_generator_if.sv
// Control and status bundle for tick_generator: the consumer side drives
// configuration and strobes, the generator side returns tick/wave/busy/elapsed.
interface tick_generator_if #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned ECW   = 8
);
    logic             enable;
    logic             div_load;
    logic [WIDTH-1:0] div_in;
    logic [1:0]       mode;
    logic             start;
    logic             clear_elapsed;
    logic             tick;
    logic             wave;
    logic             busy;
    logic [ECW-1:0]   elapsed;

    modport master (
        output enable, div_load, div_in, mode, start, clear_elapsed,
        input  tick, wave, busy, elapsed
    );

    modport slave (
        input  enable, div_load, div_in, mode, start, clear_elapsed,
        output tick, wave, busy, elapsed
    );
endinterface

// File: rtl/tick_generator.sv
// Programmable clock-enable generator: periodic, one-shot and square-wave
// modes with run-time divisor, freeze and a wrapping tick counter.
module tick_generator #(
    parameter int unsigned WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 5,
    parameter int unsigned ECW         = 8
) (
    input logic             clock,
    input logic             reset,
    tick_generator_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_RESERVED = 2'b11
    } mode_e;

    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] q;
    mode_e            mode_q;
    mode_e            mode_in;
    logic             tick_q;
    logic             wave_q;
    logic             busy_q;
    logic [ECW-1:0]   elapsed_q;

    logic load_ok;
    logic mode_chg;
    logic terminal;
    logic tick_set;

    assign mode_in  = mode_e'(bus.mode);
    assign load_ok  = bus.div_load && (bus.div_in != '0);
    assign mode_chg = (mode_in != mode_q);
    assign terminal = (q == div_q - WIDTH'(1));

    // Whether tick goes high on this edge; shared by the tick register and
    // the elapsed counter so both see the same decision.
    always_comb begin
        tick_set = 1'b0;
        if (!load_ok && !mode_chg && bus.enable && terminal) begin
            if (mode_q == MODE_ONESHOT)
                tick_set = busy_q && !bus.start;
            else
                tick_set = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q     <= WIDTH'(DEFAULT_DIV);
            q         <= '0;
            mode_q    <= mode_in;
            tick_q    <= 1'b0;
            wave_q    <= 1'b0;
            busy_q    <= 1'b0;
            elapsed_q <= '0;
        end else begin
            if (bus.clear_elapsed)
                elapsed_q <= '0;
            else if (tick_set)
                elapsed_q <= elapsed_q + ECW'(1);

            if (load_ok) begin
                div_q  <= bus.div_in;
                q      <= '0;
                tick_q <= 1'b0;
                busy_q <= 1'b0;
            end else if (mode_chg) begin
                mode_q <= mode_in;
                q      <= '0;
                tick_q <= 1'b0;
                busy_q <= 1'b0;
                wave_q <= 1'b0;
            end else if (!bus.enable) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= tick_set;
                case (mode_q)
                    MODE_ONESHOT: begin
                        wave_q <= 1'b0;
                        if (bus.start) begin
                            q      <= '0;
                            busy_q <= 1'b1;
                        end else if (busy_q) begin
                            if (terminal) begin
                                q      <= '0;
                                busy_q <= 1'b0;
                            end else begin
                                q <= q + WIDTH'(1);
                            end
                        end else begin
                            q <= '0;
                        end
                    end
                    MODE_SQUARE: begin
                        q <= terminal ? '0 : q + WIDTH'(1);
                        if (terminal)
                            wave_q <= ~wave_q;
                    end
                    default: begin
                        q      <= terminal ? '0 : q + WIDTH'(1);
                        wave_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.tick    = tick_q;
    assign bus.wave    = wave_q;
    assign bus.busy    = busy_q;
    assign bus.elapsed = elapsed_q;
endmodule

// File: tb/tb_tick_generator.sv
// Randomized and directed bench for tick_generator against an event-count
// reference model.
module tb_tick_generator;
    localparam int unsigned WIDTH = 28;
    localparam int unsigned DEF   = 5;
    localparam int unsigned ECW   = 4;
    localparam int unsigned EMOD  = 1 << ECW;

    logic clock;
    logic reset;

    tick_generator_if #(.WIDTH(WIDTH), .ECW(ECW)) bus ();

    tick_generator #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF), .ECW(ECW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: counts enabled cycles since the last restart and
    // issues a tick once that count reaches the divisor.
    int m_div;
    int m_cnt;
    int m_mode;
    bit m_active;
    bit m_tick;
    bit m_wave;
    int m_elapsed;
    int tick_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit nt;
        nt = 1'b0;
        if (reset) begin
            m_div = DEF; m_cnt = 0; m_mode = int'(bus.mode);
            m_active = 0; m_wave = 0; m_elapsed = 0; m_tick = 0;
            return;
        end
        if (bus.div_load && bus.div_in != 0) begin
            m_div = int'(bus.div_in); m_cnt = 0; m_active = 0;
        end else if (int'(bus.mode) != m_mode) begin
            m_mode = int'(bus.mode); m_cnt = 0; m_active = 0; m_wave = 0;
        end else if (bus.enable) begin
            if (m_mode == 1) begin
                if (bus.start) begin
                    m_active = 1; m_cnt = 0;
                end else if (m_active) begin
                    m_cnt++;
                    if (m_cnt == m_div) begin
                        nt = 1; m_active = 0; m_cnt = 0;
                    end
                end
            end else begin
                m_cnt++;
                if (m_cnt == m_div) begin
                    nt = 1; m_cnt = 0;
                    if (m_mode == 2) m_wave = !m_wave;
                end
            end
        end
        if (bus.clear_elapsed) m_elapsed = 0;
        else if (nt) m_elapsed = (m_elapsed + 1) % EMOD;
        m_tick = nt;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        if (bus.tick) tick_seen++;
        check("tick", 32'(bus.tick), 32'(m_tick));
        check("wave", 32'(bus.wave), 32'(m_wave));
        check("busy", 32'(bus.busy), 32'(m_active));
        check("elapsed", 32'(bus.elapsed), 32'(m_elapsed));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_div(input int d);
        bus.div_load = 1'b1;
        bus.div_in   = WIDTH'(d);
        cycle();
        bus.div_load = 1'b0;
        bus.div_in   = '0;
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;
        bus.mode = 2'b00; bus.start = 1'b0; bus.clear_elapsed = 1'b0;
        tick_seen = 0;
        run(2);
        check("rst_tick", 32'(bus.tick), 32'd0);
        check("rst_elapsed", 32'(bus.elapsed), 32'd0);

        // Periodic, default divisor: ticks on cycles 5, 10, 15.
        reset = 1'b0; bus.enable = 1'b1;
        tick_seen = 0;
        run(15);
        check("per_ticks", 32'(tick_seen), 32'd3);
        check("per_elapsed", 32'(bus.elapsed), 32'd3);

        // Divisor load mid-count, then an ignored zero load.
        run(3);
        load_div(3);
        check("load_no_tick", 32'(bus.tick), 32'd0);
        run(9);
        load_div(0);
        run(6);

        // One-shot with restart: exactly one tick after the second start.
        bus.mode = 2'b01;
        cycle();
        load_div(4);
        tick_seen = 0;
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        check("os_busy", 32'(bus.busy), 32'd1);
        cycle();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        run(10);
        check("os_ticks", 32'(tick_seen), 32'd1);
        check("os_idle", 32'(bus.busy), 32'd0);

        // Square wave, P=2, then back to periodic.
        bus.mode = 2'b10;
        cycle();
        load_div(2);
        run(12);
        bus.mode = 2'b00;
        cycle();
        check("sq_exit_wave", 32'(bus.wave), 32'd0);
        run(3);

        // Enable freeze mid-count.
        load_div(5);
        run(2);
        bus.enable = 1'b0;
        tick_seen = 0;
        run(3);
        check("freeze_ticks", 32'(tick_seen), 32'd0);
        bus.enable = 1'b1;
        run(10);

        // P=1: wrap of elapsed, then clear coinciding with a tick.
        load_div(1);
        run(20);
        bus.clear_elapsed = 1'b1; cycle(); bus.clear_elapsed = 1'b0;
        check("clr_elapsed", 32'(bus.elapsed), 32'd0);
        run(3);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            reset             = ($urandom_range(0, 199) == 0);
            bus.enable        = ($urandom_range(0, 9) < 8);
            bus.div_load      = ($urandom_range(0, 19) == 0);
            bus.div_in        = WIDTH'($urandom_range(0, 6));
            bus.start         = ($urandom_range(0, 9) == 0);
            bus.clear_elapsed = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
